// File: rtl/vga_fb_arbiter_if.sv
// Writer request/acknowledge channel for the frame-buffer arbiter.
//   wr_req  : writer wants a write. It holds the request, address and data
//             until it sees wr_ack.
//   wr_addr : frame-buffer address to write.
//   wr_data : pixel to write.
//   wr_ack  : one-cycle pulse in the cycle the write is presented to the RAM.
// Modports: master = pixel writer (drawing engine / CPU bridge),
//           slave  = arbiter.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: owns the single-port pixel RAM and shares it between
// the display prefetch FIFO and a req/ack pixel writer. All logic is in the
// pixel clock domain.
// Ports:
//   pxl_clk, rst (synchronous, active low)
//   frame_start        : restart fetching from address 0 (flushes the FIFO)
//   pix_rd / pix_data / pix_valid : first-word fall-through display FIFO
//   underrun           : sticky, pix_rd seen while the FIFO was empty
//   wr_if (slave)      : writer req/ack channel
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM port, rdata one cycle
//                        after the read is presented
// Build option: define VGA_FB_ARB_UNDERRUN_CNT_EN to add a 16-bit saturating
// underrun event counter on output underrun_cnt.
//
// state | meaning
// DONE  | frame fully fetched (or after reset): writer only
// FLUSH | one cycle after frame_start: FIFO emptied, no RAM access
// RUN   | fetching the frame, arbitrating against the writer
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FRAME_PIX  = 76800,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 8
) (
    input  logic              pxl_clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underrun,
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    vga_fb_arbiter_if.slave   wr_if,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_DONE = 2'd0, ST_FLUSH = 2'd1, ST_RUN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
    logic [DATA_W-1:0] last_q, last_d;
    logic              rd_issue_q, rd_issue_d;  // read presented to RAM this cycle
    logic              rd_pend_q, rd_pend_d;    // read data on mem_rdata this cycle
    logic              underrun_q, underrun_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [LVL_W:0]    occupancy;
    logic              fetch_ok, wr_ok, low_level, empty;
    logic              grant_fetch, grant_write, push, pop;

    // Reads already granted but not yet in the FIFO still claim a slot,
    // which is what keeps the push from ever overflowing.
    assign occupancy = {1'b0, level_q} + (LVL_W + 1)'(rd_issue_q) + (LVL_W + 1)'(rd_pend_q);
    assign fetch_ok  = (state_q == ST_RUN) && (occupancy < (LVL_W + 1)'(FIFO_DEPTH));
    assign low_level = level_q < LVL_W'(LOW_WATER);
    assign empty     = (level_q == '0);
    // A request seen in its own ack cycle is the one just served.
    assign wr_ok     = wr_if.wr_req && !wr_ack_q && (state_q != ST_FLUSH);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_d       = fifo_q;
        last_d       = last_q;
        underrun_d   = underrun_q | (pix_rd && empty);
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        wr_ack_d     = 1'b0;
        grant_fetch  = 1'b0;
        grant_write  = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        if (!frame_start) begin
            if (fetch_ok && low_level) begin
                grant_fetch = 1'b1;
            end else if (wr_ok) begin
                grant_write = 1'b1;
            end else if (fetch_ok) begin
                grant_fetch = 1'b1;
            end
            push = rd_pend_q;
            pop  = pix_rd && !empty;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            last_d   = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        rd_issue_d = grant_fetch;
        rd_pend_d  = rd_issue_q && !frame_start;

        if (grant_fetch) begin
            mem_en_d     = 1'b1;
            mem_addr_d   = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        end
        if (grant_write) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_if.wr_addr;
            mem_wdata_d = wr_if.wr_data;
            wr_ack_d    = 1'b1;
        end

        if (frame_start) begin
            state_d      = ST_FLUSH;
            fetch_addr_d = '0;
            level_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            case (state_q)
                ST_FLUSH: state_d = ST_RUN;
                ST_RUN:   if (grant_fetch && fetch_addr_q == ADDR_W'(FRAME_PIX - 1)) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (!rst) begin
            state_q      <= ST_DONE;
            fetch_addr_q <= '0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_q       <= '0;
            rd_issue_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            underrun_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_q       <= last_d;
            rd_issue_q   <= rd_issue_d;
            rd_pend_q    <= rd_pend_d;
            underrun_q   <= underrun_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // Storage needs no reset: an empty FIFO shows last_q, never the array.
    always_ff @(posedge pxl_clk) begin
        fifo_q <= fifo_d;
    end

    assign pix_valid    = !empty;
    assign pix_data     = empty ? last_q : fifo_q[rd_ptr_q];
    assign underrun     = underrun_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign wr_if.wr_ack = wr_ack_q;

`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (pix_rd && empty && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge pxl_clk) begin
        if (!rst) ucnt_q <= '0;
        else      ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a behavioural RAM, a req/ack writer, and a
// queue-based reference model of the display FIFO and the arbitration rules.
// A short frame (FRAME_PIX=300) keeps whole-frame runs cheap.
module tb_vga_fb_arbiter;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int FRAME_PIX  = 300;
    localparam int FIFO_DEPTH = 16;
    localparam int LOW_WATER  = 8;
    localparam int P_DONE = 0, P_FLUSH = 1, P_RUN = 2;

    logic              pxl_clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_rd = 1'b0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid, underrun;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIX(FRAME_PIX),
        .FIFO_DEPTH(FIFO_DEPTH), .LOW_WATER(LOW_WATER)
    ) dut (
        .pxl_clk(pxl_clk), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .wr_if(wr_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 pxl_clk = ~pxl_clk;

    // Behavioural synchronous RAM with a computed power-up image.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    bit                wrt [0:(1<<ADDR_W)-1];

    function automatic int init_pix(input int a);
        return (((a * 37) + 5) ^ (a >> 3)) & ((1 << DATA_W) - 1);
    endfunction

    function automatic int ram_rd(input int a);
        return wrt[a] ? int'(ram[a]) : init_pix(a);
    endfunction

    always @(posedge pxl_clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wrt[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= DATA_W'(ram_rd(int'(mem_addr)));
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int q[$];
    int m_phase, m_faddr, m_iss_addr, m_ret_data, m_ucnt;
    bit m_iss, m_ret, m_ur;
    bit e_en, e_we, e_ack;
    int e_addr, e_wdata;
    // Writer
    bit w_on, w_req;
    int w_pct, w_addr, w_data;
    // Observation counters
    int n_dut_reads;
    bit cap_first;
    int first_rd_addr;

    task automatic model_reset();
        q.delete();
        m_phase = P_DONE; m_faddr = 0; m_iss = 0; m_ret = 0; m_ur = 0; m_ucnt = 0;
        m_iss_addr = 0; m_ret_data = 0;
        e_en = 0; e_we = 0; e_ack = 0; e_addr = 0; e_wdata = 0;
    endtask

    task automatic check_outputs();
        chk("pix_valid", 32'(pix_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("pix_data", 32'(pix_data), q[0]);
        chk("underrun", 32'(underrun), 32'(m_ur));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("wr_ack", 32'(wr_if.wr_ack), 32'(e_ack));
        if (e_en) chk("mem_addr", 32'(mem_addr), e_addr);
        if (e_we) chk("mem_wdata", 32'(mem_wdata), e_wdata);
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), m_ucnt);
`endif
        if (mem_en && !mem_we) begin
            n_dut_reads++;
            if (cap_first && first_rd_addr < 0) first_rd_addr = int'(mem_addr);
        end
    endtask

    // One clock: check at the falling edge, drive inputs, advance the model
    // across the following rising edge.
    task automatic cycle(input bit fs, input bit rd, input bit rst_n);
        int lvl, outst;
        bit fok, wok, gf, gw;
        @(negedge pxl_clk);
        check_outputs();
        if (e_ack || !w_req) begin
            if (w_on && $urandom_range(0, 99) < w_pct) begin
                w_req  = 1;
                w_addr = $urandom_range(0, FRAME_PIX - 1);
                w_data = $urandom_range(0, (1 << DATA_W) - 1);
            end else begin
                w_req = 0;
            end
        end
        wr_if.wr_req  = w_req;
        wr_if.wr_addr = ADDR_W'(w_addr);
        wr_if.wr_data = DATA_W'(w_data);
        frame_start   = fs;
        pix_rd        = rd;
        rst           = rst_n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lvl   = q.size();
        outst = int'(m_iss) + int'(m_ret);
        fok   = (m_phase == P_RUN) && (lvl + outst < FIFO_DEPTH);
        wok   = w_req && !e_ack && (m_phase != P_FLUSH);
        gf = 0; gw = 0;
        if (!fs) begin
            if (fok && lvl < LOW_WATER) gf = 1;
            else if (wok)               gw = 1;
            else if (fok)               gf = 1;
        end
        if (rd && lvl == 0) begin
            m_ur = 1;
            if (m_ucnt < 65535) m_ucnt++;
        end
        if (!fs) begin
            if (rd && lvl > 0) void'(q.pop_front());
            if (m_ret) q.push_back(m_ret_data);
        end
        // Data of the read visible now is what the RAM holds at this point.
        m_ret      = m_iss && !fs;
        m_ret_data = ram_rd(m_iss_addr);
        m_iss      = gf;
        m_iss_addr = m_faddr;
        e_en    = gf || gw;
        e_we    = gw;
        e_ack   = gw;
        e_addr  = gw ? w_addr : (gf ? m_faddr : 0);
        e_wdata = gw ? w_data : 0;
        if (fs) begin
            q.delete();
            m_faddr = 0;
            m_phase = P_FLUSH;
        end else if (m_phase == P_FLUSH) begin
            m_phase = P_RUN;
        end else if (gf) begin
            if (m_faddr == FRAME_PIX - 1) m_phase = P_DONE;
            m_faddr++;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        @(posedge pxl_clk);
        #1;
        chk({pfx, "_pix_data"}, 32'(pix_data), 0);
        chk({pfx, "_pix_valid"}, 32'(pix_valid), 0);
        chk({pfx, "_underrun"}, 32'(underrun), 0);
        chk({pfx, "_mem_en"}, 32'(mem_en), 0);
        chk({pfx, "_mem_we"}, 32'(mem_we), 0);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
        chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({pfx, "_wr_ack"}, 32'(wr_if.wr_ack), 0);
    endtask

    initial begin
        int cnt;
        bit found;
        wr_if.wr_req = 0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        w_on = 0; w_req = 0; w_pct = 0; w_addr = 0; w_data = 0;
        cap_first = 0; first_rd_addr = -1; n_dut_reads = 0;
        model_reset();
        repeat (2) @(posedge pxl_clk);
        cycle(0, 0, 0);
        check_all_zero("rst");

        // Fill: 16 consecutive reads, then nothing.
        cycle(1, 0, 1);
        n_dut_reads = 0;
        repeat (30) cycle(0, 0, 1);
        chk("fill_reads", 32'(n_dut_reads), 16);
        chk("fill_valid", 32'(pix_valid), 1);
        chk("fill_head", 32'(pix_data), init_pix(0));

        // Whole frame with the display popping every cycle.
        cycle(1, 0, 1);
        n_dut_reads = 0;
        repeat (20) cycle(0, 0, 1);
        cnt = 0;
        while (cnt < 2000 && !(m_phase == P_DONE && q.size() == 0 && !m_iss && !m_ret)) begin
            cycle(0, 1, 1);
            cnt++;
        end
        chk("frame_timeout", 32'(cnt < 2000), 1);
        chk("frame_reads", 32'(n_dut_reads), FRAME_PIX);
        chk("frame_no_underrun", 32'(underrun), 0);

        // DONE: writer only.
        w_on = 1; w_pct = 100;
        n_dut_reads = 0;
        repeat (30) cycle(0, 0, 1);
        chk("done_no_reads", 32'(n_dut_reads), 0);

        // frame_start with a read in flight at level 10.
        w_on = 0;
        for (int i = 0; i < 10 && w_req; i++) cycle(0, 0, 1);
        cycle(1, 0, 1);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 10 && m_iss) begin
                found = 1;
                break;
            end
            cycle(0, 0, 1);
        end
        chk("fs_setup", 32'(found), 1);
        cycle(1, 0, 1);
        @(posedge pxl_clk);
        #1;
        chk("fs_flush_valid", 32'(pix_valid), 0);
        cap_first = 1; first_rd_addr = -1;
        repeat (6) cycle(0, 0, 1);
        cap_first = 0;
        chk("fs_first_addr", first_rd_addr, 0);
        repeat (20) cycle(0, 0, 1);
        chk("fs_head", 32'(pix_data), ram_rd(0));

        // Pop on an empty FIFO.
        cycle(1, 0, 1);
        cycle(0, 1, 1);
        @(posedge pxl_clk);
        #1;
        chk("ur_set", 32'(underrun), 1);
        chk("ur_level", 32'(pix_valid), 0);
`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
        chk("ucnt_one", 32'(underrun_cnt), 1);
`endif

        // Random traffic with writer, display pops and occasional restarts.
        w_on = 1; w_pct = 40;
        for (int i = 0; i < 1500; i++) begin
            bit fs_r, rd_r;
            fs_r = ($urandom_range(0, 199) == 0);
            rd_r = !fs_r && ($urandom_range(0, 99) < 60);
            cycle(fs_r, rd_r, 1);
        end

        // Reset in the middle of a frame.
        w_on = 0;
        for (int i = 0; i < 10 && w_req; i++) cycle(0, 0, 1);
        cycle(1, 0, 1);
        repeat (10) cycle(0, 0, 1);
        cycle(0, 0, 0);
        check_all_zero("rst_mid");
        n_dut_reads = 0;
        repeat (20) cycle(0, 0, 1);
        chk("rst_no_fetch", 32'(n_dut_reads), 0);

`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
        repeat (70000) cycle(0, 1, 1);
        cycle(0, 0, 1);
        chk("ucnt_sat", 32'(underrun_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
